card_game_controller: RTL and testbench
=======================================

// Module: card_game_controller
// PURPOSE
//  Game-state engine for the 4x4 memory card game. It produces the face-up card map and the
//  cursor position that the VGA grid renderer draws each frame. Inputs are debounced buttons;
//  it owns card turning, pair comparison, the mismatch display delay and the score.
// PARAMETERS
//  LAYOUT       48'hFAC688_FAC688  card k face value = LAYOUT[3k+2:3k], k = row*4+col, values 0..7
//  SHOW_CYCLES  25_000_000         cycles a mismatched pair stays face-up (1 s at 25 MHz), >= 1
// PORTS
//  clk           in   1   pixel/system clock, single clock domain
//  rst           in   1   synchronous, active-high reset
//  btn_up        in   1   debounced level, cursor row -1
//  btn_down      in   1   debounced level, cursor row +1
//  btn_left      in   1   debounced level, cursor col -1
//  btn_right     in   1   debounced level, cursor col +1
//  btn_sel       in   1   debounced level, turn card under cursor / restart when game over
//  open_cards    out  16  bit row*4+col = 1 -> card face-up
//  current_x     out  2   cursor column
//  current_y     out  2   cursor row
//  pairs_found   out  4   matched pairs, 0..8
//  moves         out  8   completed two-card attempts, saturates at 255
//  match_pulse   out  1   1-cycle strobe on a match
//  mismatch_pulse out 1   1-cycle strobe on a mismatch
//  game_over     out  1   high while in DONE
// BEHAVIOUR
//  - Reset values:
//    - All outputs 0; cursor is (0,0); state is PICK1.
//    - Button history registers reset to 1, so a button held through reset does not fire.
//    - rst overrides every other event in the same cycle, including mid-SHOW.
//  - Press detection: press = btn & ~btn_q. One press per rising edge; holding a button has no
//    further effect.
//  - Cursor moves in PICK1, PICK2 and SHOW. It is frozen in CHECK and DONE.
//    - Moves wrap mod 4: left at col 0 gives col 3; down at row 3 gives row 0.
//    - Up+down pressed together: row unchanged. Left+right together: column unchanged.
//    - One row and one column move in the same cycle both apply.
//  - Select acts on the cursor position registered before any same-cycle move.
//  - FSM:
//    - PICK1: select on a face-down card sets its bit, latches idx1, goes to PICK2.
//      Select on a face-up card is ignored.
//    - PICK2: select on a face-down card sets its bit, latches idx2, increments moves
//      (saturating), goes to CHECK. Select on a face-up card is ignored.
//    - CHECK (1 cycle): compare LAYOUT values at idx1 and idx2.
//      - Equal: match_pulse=1, pairs_found+1, bits stay set. Go to DONE if pairs_found becomes 8,
//        otherwise to PICK1.
//      - Not equal: mismatch_pulse=1, load cnt=SHOW_CYCLES-1, go to SHOW.
//    - SHOW: select is ignored. cnt decrements each cycle. In the cycle cnt==0, clear bits idx1
//      and idx2 and go to PICK1. Cards stay visible for SHOW_CYCLES cycles after CHECK.
//    - DONE: game_over=1 and moves are ignored. A select press clears open_cards, pairs_found,
//      moves and the cursor, then goes to PICK1.
//  - Latency:
//    - open_cards bit is set 1 cycle after the select press cycle.
//    - pulses are asserted 1 cycle after the PICK2 select.
//  - cnt width is $clog2(SHOW_CYCLES+1). pairs_found is 4 bits, so 8 is representable.
//  - All outputs are registered; no combinational input-to-output path.
// TESTING (SHOW_CYCLES=4, default LAYOUT)
//  1. Assert rst with btn_sel held high, then release rst -> all outputs 0, cursor (0,0),
//     no card turned while btn_sel stays high.
//  2. left at (0,0) -> current_x=3; 4x down -> current_y back to 0.
//     up+down in one cycle -> row unchanged.
//  3. Select (0,0); down,down; select (2,0) -> open_cards=16'h0101, match_pulse once,
//     pairs_found=1, moves=1.
//  4. Select (0,1) then (0,2) -> mismatch_pulse, bits 1,2 set for exactly 4 cycles, then
//     open_cards back to prior value. Selects during SHOW have no effect.
//  5. Select an already face-up card in PICK1 or PICK2 -> no state or bit change.
//     rst asserted mid-SHOW -> full reset next cycle.
//  6. Play all 8 pairs -> game_over=1, pairs_found=8, moves=8; moves ignored.
//     select -> everything cleared, PICK1.

Source files
------------

// File: rtl/card_game_controller.sv
// card_game_controller: state engine for the 4x4 memory card game.
// Owns the cursor, card turning, pair checks, mismatch hold and score.
module card_game_controller #(
  parameter logic [47:0] LAYOUT      = 48'hFAC688_FAC688,
  parameter int unsigned SHOW_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [15:0] open_cards,
  output logic [1:0]  current_x,
  output logic [1:0]  current_y,
  output logic [3:0]  pairs_found,
  output logic [7:0]  moves,
  output logic        match_pulse,
  output logic        mismatch_pulse,
  output logic        game_over
);

  localparam int unsigned CW = $clog2(SHOW_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PICK1,
    S_PICK2,
    S_CHECK,
    S_SHOW,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [4:0]    r_btn_q;
  logic [4:0]    w_btn;
  logic [4:0]    w_press;
  logic          w_move_en;
  logic [3:0]    w_cur;

  logic [1:0]    r_x;
  logic [1:0]    r_y;
  logic [15:0]   r_open;
  logic [3:0]    r_idx1;
  logic [3:0]    r_idx2;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_pairs;
  logic [7:0]    r_moves;
  logic          r_match;
  logic          r_mis;
  logic          r_over;

  logic [1:0]    w_x_nxt;
  logic [1:0]    w_y_nxt;
  logic [15:0]   w_open_nxt;
  logic [3:0]    w_idx1_nxt;
  logic [3:0]    w_idx2_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_pairs_nxt;
  logic [7:0]    w_moves_nxt;
  logic          w_match_nxt;
  logic          w_mis_nxt;

  function automatic logic [2:0] face(input logic [3:0] k);
    logic [5:0] b;
    b = {1'b0, k, 1'b0} + {2'b00, k};
    return LAYOUT[b +: 3];
  endfunction

  // button order: sel, right, left, down, up
  assign w_btn     = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign w_press   = w_btn & ~r_btn_q;
  assign w_cur     = {r_y, r_x};
  assign w_move_en = (r_state == S_PICK1) ||
                     (r_state == S_PICK2) ||
                     (r_state == S_SHOW);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PICK1;
    else     r_state <= w_state_nxt;
  end

  // next state, cursor, card map and score
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_open_nxt  = r_open;
    w_idx1_nxt  = r_idx1;
    w_idx2_nxt  = r_idx2;
    w_cnt_nxt   = r_cnt;
    w_pairs_nxt = r_pairs;
    w_moves_nxt = r_moves;
    w_match_nxt = 1'b0;
    w_mis_nxt   = 1'b0;

    if (w_move_en) begin
      if (w_press[1] && !w_press[0])      w_y_nxt = r_y + 2'd1;
      else if (w_press[0] && !w_press[1]) w_y_nxt = r_y - 2'd1;
      if (w_press[3] && !w_press[2])      w_x_nxt = r_x + 2'd1;
      else if (w_press[2] && !w_press[3]) w_x_nxt = r_x - 2'd1;
    end

    unique case (r_state)
      S_PICK1: begin
        if (w_press[4] && !r_open[w_cur]) begin
          w_open_nxt[w_cur] = 1'b1;
          w_idx1_nxt        = w_cur;
          w_state_nxt       = S_PICK2;
        end
      end
      S_PICK2: begin
        if (w_press[4] && !r_open[w_cur]) begin
          w_open_nxt[w_cur] = 1'b1;
          w_idx2_nxt        = w_cur;
          if (r_moves != 8'hFF) w_moves_nxt = r_moves + 8'd1;
          // pulses land in the CHECK cycle; CHECK reuses the result
          if (face(r_idx1) == face(w_cur)) w_match_nxt = 1'b1;
          else                             w_mis_nxt   = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_match) begin
          w_pairs_nxt = r_pairs + 4'd1;
          w_state_nxt = (r_pairs == 4'd7) ? S_DONE : S_PICK1;
        end else begin
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_SHOW;
        end
      end
      S_SHOW: begin
        if (r_cnt == '0) begin
          w_open_nxt[r_idx1] = 1'b0;
          w_open_nxt[r_idx2] = 1'b0;
          w_state_nxt        = S_PICK1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        if (w_press[4]) begin
          w_open_nxt  = '0;
          w_pairs_nxt = '0;
          w_moves_nxt = '0;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = S_PICK1;
        end
      end
      default: w_state_nxt = S_PICK1;
    endcase
  end

  // datapath registers; button history resets high to swallow held keys
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_q <= '1;
      r_x     <= '0;
      r_y     <= '0;
      r_open  <= '0;
      r_idx1  <= '0;
      r_idx2  <= '0;
      r_cnt   <= '0;
      r_pairs <= '0;
      r_moves <= '0;
      r_match <= 1'b0;
      r_mis   <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_btn_q <= w_btn;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_open  <= w_open_nxt;
      r_idx1  <= w_idx1_nxt;
      r_idx2  <= w_idx2_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pairs <= w_pairs_nxt;
      r_moves <= w_moves_nxt;
      r_match <= w_match_nxt;
      r_mis   <= w_mis_nxt;
      r_over  <= (w_state_nxt == S_DONE);
    end
  end

  assign open_cards     = r_open;
  assign current_x      = r_x;
  assign current_y      = r_y;
  assign pairs_found    = r_pairs;
  assign moves          = r_moves;
  assign match_pulse    = r_match;
  assign mismatch_pulse = r_mis;
  assign game_over      = r_over;

endmodule

// File: tb/tb_card_game_controller.sv
// tb_card_game_controller: vector table, directed games and
// random play against a game-rules model.
module tb_card_game_controller;

  localparam logic [47:0] LAYOUT = 48'hFAC688_FAC688;
  localparam int SHOW = 4;
  localparam logic [4:0] U = 5'b00001;
  localparam logic [4:0] D = 5'b00010;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] R = 5'b01000;
  localparam logic [4:0] S = 5'b10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [15:0] open_cards;
  logic [1:0]  current_x, current_y;
  logic [3:0]  pairs_found;
  logic [7:0]  moves;
  logic        match_pulse, mismatch_pulse, game_over;

  card_game_controller #(.LAYOUT(LAYOUT), .SHOW_CYCLES(SHOW)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel),
    .open_cards(open_cards),
    .current_x(current_x), .current_y(current_y),
    .pairs_found(pairs_found), .moves(moves),
    .match_pulse(match_pulse),
    .mismatch_pulse(mismatch_pulse),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [4:0]  btn;
    logic [34:0] exp;
  } vec_t;
  vec_t tv[$];

  // game-rules model
  bit [15:0] m_open;
  bit [4:0]  m_prev;
  int m_x, m_y, m_pairs, m_moves, m_first, m_second, m_show;
  bit m_check, m_pend, m_done, m_mp, m_mmp;

  function automatic int face(int k);
    return int'((LAYOUT >> (3 * k)) & 48'h7);
  endfunction

  task automatic model_step(input bit r, input bit [4:0] b);
    bit [4:0] p;
    int cur;
    bit mv;
    if (r) begin
      m_open = '0; m_prev = 5'h1f;
      m_x = 0; m_y = 0; m_pairs = 0; m_moves = 0;
      m_first = -1; m_second = -1; m_show = 0;
      m_check = 0; m_pend = 0; m_done = 0; m_mp = 0; m_mmp = 0;
      return;
    end
    p = b & ~m_prev;
    m_prev = b;
    cur = m_y * 4 + m_x;
    mv = !m_check && !m_done;
    m_mp = 0; m_mmp = 0;
    if (m_check) begin
      m_check = 0;
      if (m_pend) begin
        m_pairs++;
        m_first = -1; m_second = -1;
        if (m_pairs == 8) m_done = 1;
      end else begin
        m_show = SHOW;
      end
    end else if (m_show > 0) begin
      m_show--;
      if (m_show == 0) begin
        m_open[m_first] = 0;
        m_open[m_second] = 0;
        m_first = -1; m_second = -1;
      end
    end else if (m_done) begin
      if (p[4]) begin
        m_open = '0; m_pairs = 0; m_moves = 0;
        m_x = 0; m_y = 0; m_done = 0;
      end
    end else if (p[4] && !m_open[cur]) begin
      m_open[cur] = 1;
      if (m_first < 0) begin
        m_first = cur;
      end else begin
        m_second = cur;
        if (m_moves < 255) m_moves++;
        m_check = 1;
        m_pend = (face(m_first) == face(cur));
        m_mp = m_pend;
        m_mmp = !m_pend;
      end
    end
    if (mv) begin
      m_y = (m_y + (p[1] ? 1 : 0) - (p[0] ? 1 : 0) + 4) % 4;
      m_x = (m_x + (p[3] ? 1 : 0) - (p[2] ? 1 : 0) + 4) % 4;
    end
  endtask

  function automatic logic [34:0] dut_out();
    return {open_cards, current_x, current_y, pairs_found,
            moves, match_pulse, mismatch_pulse, game_over};
  endfunction

  function automatic logic [34:0] model_out();
    return {m_open, 2'(m_x), 2'(m_y), 4'(m_pairs), 8'(m_moves),
            m_mp, m_mmp, m_done};
  endfunction

  function automatic vec_t mk(bit r, logic [4:0] b, logic [15:0] o,
                              int x, int y, int p, int mv,
                              bit m, bit mm, bit go);
    vec_t v;
    v.rst = r;
    v.btn = b;
    v.exp = {o, 2'(x), 2'(y), 4'(p), 8'(mv), m, mm, go};
    return v;
  endfunction

  task automatic chk(input string name, input logic [34:0] got,
                     input logic [34:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step(input bit r, input logic [4:0] b);
    rst = r;
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = b;
    @(posedge clk);
    model_step(r, b);
    #1;
  endtask

  task automatic step_chk(input string name, input bit r,
                          input logic [4:0] b);
    step(r, b);
    chk(name, dut_out(), model_out());
  endtask

  task automatic goto(input int k);
    for (int i = 0; i < 4 && m_x != k % 4; i++) begin
      step_chk("goto_x", 0, R);
      step_chk("goto_x", 0, 0);
    end
    for (int i = 0; i < 4 && m_y != k / 4; i++) begin
      step_chk("goto_y", 0, D);
      step_chk("goto_y", 0, 0);
    end
  endtask

  initial begin
    // reset with select held, cursor wrap and combos
    tv.push_back(mk(1, S,     16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, S,     16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, S,     16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, S,     16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, L,     16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, L | R, 16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, D,     16'h0000, 3, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 3, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, U | D, 16'h0000, 3, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 3, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, U,     16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, U,     16'h0000, 3, 3, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 3, 3, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, D,     16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, R | D, 16'h0000, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, U,     16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0000, 0, 0, 0, 0, 0, 0, 0));
    // matching pair (0,0) and (2,0)
    tv.push_back(mk(0, S,     16'h0001, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0001, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, D,     16'h0001, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0001, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, D,     16'h0001, 0, 2, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, S,     16'h0101, 0, 2, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,     16'h0101, 0, 2, 1, 1, 0, 0, 0));
    // mismatch (0,1) and (0,2), hold for four cycles
    tv.push_back(mk(0, U,     16'h0101, 0, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0101, 0, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, U,     16'h0101, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, R,     16'h0101, 1, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, S,     16'h0103, 1, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, R,     16'h0103, 2, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, S,     16'h0107, 2, 0, 1, 2, 0, 1, 0));
    tv.push_back(mk(0, D,     16'h0107, 2, 0, 1, 2, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0107, 2, 0, 1, 2, 0, 0, 0));
    tv.push_back(mk(0, D,     16'h0107, 2, 1, 1, 2, 0, 0, 0));
    tv.push_back(mk(0, S,     16'h0107, 2, 1, 1, 2, 0, 0, 0));
    tv.push_back(mk(0, 0,     16'h0101, 2, 1, 1, 2, 0, 0, 0));

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].btn);
      chk($sformatf("vec%0d", i), dut_out(), tv[i].exp);
    end

    // select on face-up cards is ignored
    goto(0);
    step_chk("sel_up_p1", 0, S);
    chk("p1_up_open", 35'(open_cards), 35'h0101);
    step_chk("rel", 0, 0);
    goto(3);
    step_chk("sel3", 0, S);
    step_chk("rel", 0, 0);
    goto(8);
    step_chk("sel_up_p2", 0, S);
    chk("p2_up_open", 35'(open_cards), 35'h0109);
    chk("p2_up_moves", 35'(moves), 35'd2);
    step_chk("rel", 0, 0);
    // reset in the middle of SHOW
    goto(4);
    step_chk("sel4", 0, S);
    step_chk("chk4", 0, 0);
    step_chk("show4", 0, 0);
    step_chk("rst_show", 1, 0);
    chk("rst_all", dut_out(), 35'h0);
    step_chk("post_rst", 0, 0);

    // full game
    for (int k = 0; k < 8; k++) begin
      goto(k);
      step_chk("g_sel1", 0, S);
      step_chk("g_rel", 0, 0);
      goto(k + 8);
      step_chk("g_sel2", 0, S);
      step_chk("g_rel", 0, 0);
      step_chk("g_idle", 0, 0);
    end
    chk("done_over", 35'(game_over), 35'd1);
    chk("done_pairs", 35'(pairs_found), 35'd8);
    chk("done_moves", 35'(moves), 35'd8);
    step_chk("done_left", 0, L);
    chk("done_frozen", 35'(current_x), 35'd3);
    step_chk("done_rel", 0, 0);
    step_chk("restart", 0, S);
    chk("restart_all", dut_out(), 35'h0);
    step_chk("restart_rel", 0, 0);

    // random play
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      bit r;
      b = 5'($urandom) & 5'($urandom);
      r = ($urandom_range(0, 299) == 0);
      step_chk("rand", r, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
